sm4_key_expand: RTL



---
 rtl/sm4_key_expand.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sm4_key_expand.sv
// sm4_key_expand: sequential SM4 key schedule. It expands a 128-bit master key
// into round keys rk0..rk31 and emits one key per clock as a valid-qualified
// stream.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   start           one-cycle request to begin expansion (sampled only in IDLE)
//   key_in[127:0]   master key; [127:96]=MK0 .. [31:0]=MK3 (sampled on accepted start)
//   cki_in[31:0]    CK word returned combinationally for count_round_out
//   count_round_out round index driven to the CK lookup (0 when idle)
//   rk_out[31:0]    registered round key
//   rk_index[4:0]   index of the key on rk_out
//   rk_valid        rk_out/rk_index valid this cycle
//   busy            high while a run is in progress
//   done            one-cycle pulse coincident with rk31

// Combinational SM4 S-box: one byte in, one byte out.
module sm4_sbox (
  input  logic [7:0] a,
  output logic [7:0] q
);
  // Row-major table with entry 0 in the top byte, so element 255-a holds S(a).
  localparam logic [255:0][7:0] SBOX_TBL = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  // 255-a == ~a for an 8-bit index.
  assign q = SBOX_TBL[~a];
endmodule

module sm4_key_expand (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [31:0]  cki_in,
  output logic [4:0]   count_round_out,
  output logic [31:0]  rk_out,
  output logic [4:0]   rk_index,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  localparam logic [127:0] FK = {32'ha3b1bac6, 32'h56aa3350,
                                 32'h677d9197, 32'hb27022dc};

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] k0, k1, k2, k3;
  logic [4:0]  cnt;

  logic [31:0]                            x, b, l_b, rk;
  logic [NUM_LANES-1:0][VEC_W-1:0]        x_lanes, t_lanes;

  // Round function datapath: tau (4 parallel S-boxes) then linear transform L'.
  assign x       = k1 ^ k2 ^ k3 ^ cki_in;
  assign x_lanes = x;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_sbox
      sm4_sbox u_sbox (
        .a (x_lanes[g]),
        .q (t_lanes[g])
      );
    end
  endgenerate

  assign b   = t_lanes;
  assign l_b = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  assign rk  = k0 ^ l_b;

  assign count_round_out = cnt;
  assign busy            = (state_q == RUN);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)        state_d = RUN;
      RUN:     if (cnt == 5'd31) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      k0       <= '0;
      k1       <= '0;
      k2       <= '0;
      k3       <= '0;
      cnt      <= '0;
      rk_out   <= '0;
      rk_index <= '0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          rk_valid <= 1'b0;
          done     <= 1'b0;
          if (start) begin
            k0  <= key_in[127:96] ^ FK[127:96];
            k1  <= key_in[95:64]  ^ FK[95:64];
            k2  <= key_in[63:32]  ^ FK[63:32];
            k3  <= key_in[31:0]   ^ FK[31:0];
            cnt <= '0;
          end
        end
        RUN: begin
          rk_out   <= rk;
          rk_index <= cnt;
          rk_valid <= 1'b1;
          done     <= (cnt == 5'd31);
          k0       <= k1;
          k1       <= k2;
          k2       <= k3;
          k3       <= rk;
          // Wraps to 0 after round 31 so the lookup index idles at 0.
          cnt      <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
